// File: rtl/sd_sector_cache.sv
// Single-sector (512 B) write-back buffer between the CPU bus and the SD block.
// Optional macro SD_CACHE_FLUSH_EN adds a cpu_flush port that writes back a dirty sector.
module sd_sector_cache #(
    parameter logic [31:0] SECTOR_BASE = 32'd0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
`ifdef SD_CACHE_FLUSH_EN
    input  logic          cpu_flush,
`endif
    output logic [31:0]   cpu_rdata,
    output logic          cpu_ready,
    output logic          cpu_err,
    output logic [31:0]   sd_addr,
    output logic          sd_re,
    output logic          sd_we,
    output logic [4095:0] sd_wdata,
    input  logic [4095:0] sd_rdata,
    input  logic          sd_read_ok,
    input  logic          sd_read_err,
    input  logic          sd_write_ok,
    input  logic          sd_write_err,
    input  logic          sd_init_ok,
    input  logic          sd_init_err
);
    typedef enum logic [2:0] {
        S_WAIT_INIT, S_IDLE, S_WB_REQ, S_WB_REL, S_RD_REQ, S_RD_REL, S_ACK, S_ERROR
    } state_t;

    state_t          state, state_nx;
    logic [4095:0]   sec_buf;
    logic [22:0]     tag;
    logic            valid, dirty, flush_pend, err_ack;
    logic [31:0]     rdata_q;
    logic [22:0]     req_sector;
    logic [6:0]      word_idx;
    logic            hit, flush_req, err_req;
    logic            rd_latch, wr_word, fill, wb_done, inval, set_flush;
    logic            unused_bits;

    assign req_sector  = cpu_addr[31:9];
    assign word_idx    = cpu_addr[8:2];
    assign unused_bits = ^cpu_addr[1:0];
    assign hit         = valid && (tag == req_sector);

`ifdef SD_CACHE_FLUSH_EN
    assign flush_req = cpu_flush;
    assign err_req   = cpu_req | cpu_flush;
`else
    assign flush_req = 1'b0;
    assign err_req   = cpu_req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_WAIT_INIT;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        rd_latch  = 1'b0;
        wr_word   = 1'b0;
        fill      = 1'b0;
        wb_done   = 1'b0;
        inval     = 1'b0;
        set_flush = 1'b0;
        case (state)
            S_WAIT_INIT: begin
                if (sd_init_ok)       state_nx = S_IDLE;
                else if (sd_init_err) state_nx = S_ERROR;
            end
            S_IDLE: begin
                if (flush_req) begin
                    if (dirty) begin
                        set_flush = 1'b1;
                        state_nx  = S_WB_REQ;
                    end else begin
                        state_nx  = S_ACK;
                    end
                end else if (cpu_req) begin
                    if (hit) begin
                        wr_word  = cpu_we;
                        rd_latch = !cpu_we;
                        state_nx = S_ACK;
                    end else begin
                        state_nx = dirty ? S_WB_REQ : S_RD_REQ;
                    end
                end
            end
            S_WB_REQ: begin
                if (sd_write_ok) begin
                    wb_done  = 1'b1;
                    state_nx = S_WB_REL;
                end else if (sd_write_err) begin
                    state_nx = S_ERROR;
                end
            end
            // Enable is low here; wait for the SD block to clear its ok.
            S_WB_REL: if (!sd_write_ok) state_nx = flush_pend ? S_ACK : S_RD_REQ;
            S_RD_REQ: begin
                if (sd_read_ok) begin
                    fill     = 1'b1;
                    state_nx = S_RD_REL;
                end else if (sd_read_err) begin
                    inval    = 1'b1;
                    state_nx = S_ERROR;
                end
            end
            S_RD_REL: if (!sd_read_ok) state_nx = S_IDLE;
            S_ACK:    state_nx = S_IDLE;
            S_ERROR:  state_nx = S_ERROR;
            default:  state_nx = S_WAIT_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec_buf    <= '0;
            tag        <= '0;
            valid      <= 1'b0;
            dirty      <= 1'b0;
            flush_pend <= 1'b0;
            err_ack    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (wr_word) begin
                sec_buf[{word_idx, 5'd0} +: 32] <= cpu_wdata;
                dirty                           <= 1'b1;
            end
            if (fill) begin
                sec_buf <= sd_rdata;
                tag     <= req_sector;
                valid   <= 1'b1;
            end
            if (wb_done) dirty <= 1'b0;
            if (inval)   valid <= 1'b0;
            if (rd_latch)              rdata_q <= sec_buf[{word_idx, 5'd0} +: 32];
            else if (state == S_ERROR) rdata_q <= '0;
            // One pulse per held request while in ERROR; the CPU drops req on seeing it.
            err_ack <= (state == S_ERROR) && err_req && !err_ack;
            if (set_flush)           flush_pend <= 1'b1;
            else if (state == S_ACK) flush_pend <= 1'b0;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_ready = (state == S_ACK) || err_ack;
    assign cpu_err   = (state == S_ERROR);
    assign sd_we     = (state == S_WB_REQ);
    assign sd_re     = (state == S_RD_REQ);
    assign sd_wdata  = sec_buf;
    always_comb begin
        sd_addr = '0;
        if (state == S_WB_REQ)      sd_addr = SECTOR_BASE + {9'd0, tag};
        else if (state == S_RD_REQ) sd_addr = SECTOR_BASE + {9'd0, req_sector};
    end
endmodule

// File: tb/tb_sd_sector_cache.sv
// Randomized bench for sd_sector_cache: SD block responder plus a CPU-view memory model.
module tb_sd_sector_cache;
    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [31:0]   cpu_addr, cpu_wdata;
`ifdef SD_CACHE_FLUSH_EN
    logic          cpu_flush;
`endif
    logic [31:0]   cpu_rdata;
    logic          cpu_ready, cpu_err;
    logic [31:0]   sd_addr;
    logic          sd_re, sd_we;
    logic [4095:0] sd_wdata, sd_rdata;
    logic          sd_read_ok, sd_read_err, sd_write_ok, sd_write_err;
    logic          sd_init_ok, sd_init_err;

    sd_sector_cache #(.SECTOR_BASE(32'd0)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
`ifdef SD_CACHE_FLUSH_EN
        .cpu_flush(cpu_flush),
`endif
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
        .sd_addr(sd_addr), .sd_re(sd_re), .sd_we(sd_we),
        .sd_wdata(sd_wdata), .sd_rdata(sd_rdata),
        .sd_read_ok(sd_read_ok), .sd_read_err(sd_read_err),
        .sd_write_ok(sd_write_ok), .sd_write_err(sd_write_err),
        .sd_init_ok(sd_init_ok), .sd_init_err(sd_init_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int s, input int i);
        return (32'(s) * 32'h9E37_79B1) ^ (32'(i) * 32'h85EB_CA6B) ^ 32'h1357_9BDF;
    endfunction

    // SD card backing store: sectors that were written back; others read as init_word.
    logic [4095:0] sd_mem[int];
    function automatic logic [4095:0] get_sector(input int s);
        logic [4095:0] v;
        if (sd_mem.exists(s)) return sd_mem[s];
        for (int i = 0; i < 128; i++) v[32*i +: 32] = init_word(s, i);
        return v;
    endfunction

    // SD block responder
    bit rd_fail  = 1'b0;
    int wr_delay = 2;
    int rd_cnt = 0, wr_cnt = 0, rd_delay = 1;
    always @(negedge clk) begin
        if (!sd_re) begin
            sd_read_ok = 1'b0; sd_read_err = 1'b0; rd_cnt = 0;
            rd_delay = int'($urandom_range(1, 4));
        end else if (!sd_read_ok && !sd_read_err) begin
            rd_cnt++;
            if (rd_cnt >= rd_delay) begin
                if (rd_fail) sd_read_err = 1'b1;
                else begin
                    sd_rdata   = get_sector(int'(sd_addr));
                    sd_read_ok = 1'b1;
                end
            end
        end
        if (!sd_we) begin
            sd_write_ok = 1'b0; sd_write_err = 1'b0; wr_cnt = 0;
        end else if (!sd_write_ok) begin
            wr_cnt++;
            if (wr_cnt >= wr_delay) begin
                sd_mem[int'(sd_addr)] = sd_wdata;
                sd_write_ok = 1'b1;
            end
        end
    end

    // Bus monitor
    int re_pulses = 0, we_pulses = 0, viol = 0, cyc = 0, re_cyc = 0, we_cyc = 0;
    logic [31:0] last_re_addr = '0, last_we_addr = '0, last_we_w2 = '0, prev_addr = '0;
    logic prev_re = 1'b0, prev_we = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (sd_re && sd_we) viol++;
        if ((sd_re && prev_re) || (sd_we && prev_we)) if (sd_addr != prev_addr) viol++;
        if (sd_re && !prev_re) begin re_pulses++; last_re_addr = sd_addr; re_cyc = cyc; end
        if (sd_we && !prev_we) begin
            we_pulses++; last_we_addr = sd_addr; last_we_w2 = sd_wdata[95:64]; we_cyc = cyc;
        end
        prev_re = sd_re; prev_we = sd_we; prev_addr = sd_addr;
    end

    // CPU-view reference: what every word should read as, and which sector is buffered.
    logic [31:0] gold[int];
    bit m_valid = 1'b0, m_dirty = 1'b0;
    int m_tag = 0;
    function automatic logic [31:0] gold_rd(input logic [31:0] a);
        if (gold.exists(int'(a >> 2))) return gold[int'(a >> 2)];
        return init_word(int'(a >> 9), int'((a >> 2) & 32'd127));
    endfunction

    task automatic wait_ready(output logic [31:0] rd, output int lat);
        bit ok;
        ok = 1'b0; lat = 0; rd = '0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (cpu_ready) begin lat = i + 1; rd = cpu_rdata; ok = 1'b1; break; end
        end
        if (!ok) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        wait_ready(rd, lat);
        cpu_req = 1'b0;
    endtask

    task automatic do_op(input string tag, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd);
        int sec, ew, er, re0, we0, lat;
        bit hit;
        logic [31:0] exp, rd;
        sec = int'(addr >> 9);
        hit = m_valid && (m_tag == sec);
        ew  = (!hit && m_dirty) ? 1 : 0;
        er  = hit ? 0 : 1;
        re0 = re_pulses; we0 = we_pulses;
        exp = gold_rd(addr);
        access(we, addr, wd, rd, lat);
        if (we) gold[int'(addr >> 2)] = wd;
        else    chk({tag, "_rdata"}, rd, exp);
        if (hit) chk({tag, "_lat"}, 32'(lat), 32'd2);
        chk({tag, "_we_cnt"}, 32'(we_pulses - we0), 32'(ew));
        chk({tag, "_re_cnt"}, 32'(re_pulses - re0), 32'(er));
        if (!hit) begin m_tag = sec; m_valid = 1'b1; m_dirty = 1'b0; end
        if (we) m_dirty = 1'b1;
    endtask

    initial begin
        logic [31:0] rd, a;
        int lat, cnt, re0, we0;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, a;
        int lat, cnt, re0, we0;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
`ifdef SD_CACHE_FLUSH_EN
        cpu_flush = 1'b0;
`endif
        sd_rdata = '0; sd_read_ok = 1'b0; sd_read_err = 1'b0;
        sd_write_ok = 1'b0; sd_write_err = 1'b0; sd_init_ok = 1'b0; sd_init_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(cpu_ready), 32'd0);
        chk("rst_err",   32'(cpu_err),   32'd0);
        chk("rst_re",    32'(sd_re),     32'd0);
        chk("rst_we",    32'(sd_we),     32'd0);
        chk("rst_addr",  sd_addr,        32'd0);
        chk("rst_rdata", cpu_rdata,      32'd0);
        reset = 1'b0;

        // T1: request waits for init, then one miss fill
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0204;
        cnt = 0;
        repeat (5) begin @(negedge clk); if (cpu_ready || sd_re) cnt++; end
        sd_init_ok = 1'b1;
        wait_ready(rd, lat);
        cpu_req = 1'b0;
        chk("t1_pre_init", 32'(cnt), 32'd0);
        chk("t1_rdata", rd, init_word(1, 1));
        chk("t1_re_cnt", 32'(re_pulses), 32'd1);
        chk("t1_re_addr", last_re_addr, 32'd1);
        chk("t1_we_cnt", 32'(we_pulses), 32'd0);
        chk("t1_err", 32'(cpu_err), 32'd0);
        m_valid = 1'b1; m_tag = 1; m_dirty = 1'b0;

        // T2: write/read hit in sector 1
        do_op("t2_wr", 1'b1, 32'h0000_0208, 32'hDEAD_BEEF);
        do_op("t2_rd", 1'b0, 32'h0000_0208, 32'h0);

        // T3: dirty eviction then fill
        do_op("t3", 1'b0, 32'h0000_0400, 32'h0);
        chk("t3_we_addr", last_we_addr, 32'd1);
        chk("t3_we_word", last_we_w2, 32'hDEAD_BEEF);
        chk("t3_re_addr", last_re_addr, 32'd2);
        chk("t3_order", 32'(we_cyc < re_cyc), 32'd1);

        // Random traffic over a few sectors
        for (int n = 0; n < 60; n++) begin
            a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 2)
                | 32'($urandom_range(0, 3));
            do_op("rnd", 1'($urandom_range(0, 1)), a, $urandom);
        end

        // T4: read error on a miss
        rd_fail = 1'b1;
        we0 = we_pulses + (m_dirty ? 1 : 0);
        re0 = re_pulses + 1;
        access(1'b0, 32'h0000_0E00, 32'h0, rd, lat);
        rd_fail = 1'b0;
        chk("t4_rdata", rd, 32'd0);
        chk("t4_err", 32'(cpu_err), 32'd1);
        chk("t4_we_cnt", 32'(we_pulses), 32'(we0));
        chk("t4_re_cnt", 32'(re_pulses), 32'(re0));
        for (int n = 0; n < 3; n++) begin
            access(1'(n & 1), 32'h0000_0204, 32'h1234_5678, rd, lat);
            chk("t4_err_rdata", rd, 32'd0);
            chk("t4_err_lat", 32'(lat), 32'd2);
        end
        chk("t4_no_sd", 32'(re_pulses - re0 + we_pulses - we0), 32'd0);
        chk("t4_err_sticky", 32'(cpu_err), 32'd1);

        // T5: reset during write-back
        @(negedge clk);
        reset = 1'b1; sd_init_ok = 1'b0;
        @(negedge clk);
        reset = 1'b0; sd_init_ok = 1'b1;
        m_valid = 1'b0; m_dirty = 1'b0;
        do_op("t5_wr", 1'b1, 32'h0000_0A10, 32'hCAFE_F00D);
        wr_delay = 30;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0C00;
        cnt = 0;
        while (!sd_we && cnt < 50) begin @(negedge clk); cnt++; end
        chk("t5_we_seen", 32'(sd_we), 32'd1);
        reset = 1'b1; sd_init_ok = 1'b0;
        #1;
        chk("t5_we_drop", 32'(sd_we), 32'd0);
        chk("t5_re_drop", 32'(sd_re), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        repeat (8) begin @(negedge clk); if (cpu_ready || sd_re || sd_we) cnt++; end
        chk("t5_quiet", 32'(cnt), 32'd0);
        gold.delete(int'(32'h0000_0A10 >> 2));
        wr_delay = 2;
        sd_init_ok = 1'b1;
        wait_ready(rd, lat);
        cpu_req = 1'b0;
        chk("t5_rdata", rd, init_word(6, 0));
        m_valid = 1'b1; m_tag = 6; m_dirty = 1'b0;
        do_op("t5_lost", 1'b0, 32'h0000_0A10, 32'h0);

`ifdef SD_CACHE_FLUSH_EN
        // T6: flush of dirty sector 3, then a flush with nothing to write
        do_op("t6_wr", 1'b1, 32'h0000_0610, 32'h0BAD_CAFE);
        for (int k = 0; k < 2; k++) begin
            we0 = we_pulses; re0 = re_pulses;
            @(negedge clk);
            cpu_flush = 1'b1;
            wait_ready(rd, lat);
            cpu_flush = 1'b0;
            chk("t6_we_cnt", 32'(we_pulses - we0), (k == 0) ? 32'd1 : 32'd0);
            chk("t6_re_cnt", 32'(re_pulses - re0), 32'd0);
            if (k == 0) chk("t6_we_addr", last_we_addr, 32'd3);
        end
        m_dirty = 1'b0;
        do_op("t6_rd", 1'b0, 32'h0000_0610, 32'h0);
`endif

        repeat (3) @(negedge clk);
        chk("sd_excl_stable", 32'(viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
